// File: rtl/trace_pkg.sv
// trace_pkg: shared types and constants for the debug trace encoder.
//   - 4-bit code types for the instruction, hazard and ALU enums. They are
//     kept width-compatible with the consumer-side enum helpers that decode
//     them back into enums.
//   - trace_rec_t: one 32-bit trace record, transmitted MSB byte first.
//   - Header values, largest legal code values and sanitised replacements.
//   - Serializer state encoding.
package trace_pkg;

    typedef logic [3:0] instruction_t;
    typedef logic [3:0] hazard_signal_t;
    typedef logic [3:0] alu_op_t;

    localparam logic [3:0] HDR_SAMPLE = 4'h5;
    localparam logic [3:0] HDR_OVF    = 4'hE;

    // Largest legal code per field and the value substituted for an illegal code.
    localparam instruction_t   INSTR_MAX  = 4'hB;
    localparam hazard_signal_t HAZ_MAX    = 4'hB;
    localparam alu_op_t        ALU_MAX    = 4'hB;
    localparam instruction_t   INSTR_NONE = 4'hB;
    localparam hazard_signal_t HAZ_NONE   = 4'hB;
    localparam alu_op_t        ALU_NONE   = 4'hA;

    localparam logic [3:0] CNT_MAX = 4'hF;

    typedef struct packed {
        logic [3:0]     hdr;
        instruction_t   instr_a;
        instruction_t   instr_b;
        hazard_signal_t haz_a;
        hazard_signal_t haz_b;
        alu_op_t        alu_a;
        alu_op_t        alu_b;
        logic [3:0]     delta;
    } trace_rec_t;

    typedef logic [0:0] ser_state_t;
    localparam ser_state_t ST_IDLE = 1'b0;
    localparam ser_state_t ST_SEND = 1'b1;

    // Saturating 4-bit increment.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == CNT_MAX) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO of DEPTH x 32-bit trace records.
// Ports:
//   clk, reset        clock, synchronous active-high reset (empties the FIFO)
//   push, push_data   write request / record (ignored when full)
//   pop, pop_data     read request (ignored when empty) / head record (show-ahead)
//   full, empty       occupancy flags, derived from registered state only
module trace_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [31:0] pop_data,
    output logic        full,
    output logic        empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dbg_trace_encoder.sv
// dbg_trace_encoder: encodes per-cycle dual-lane pipeline status into 32-bit
// trace records, buffers them, and streams them out MSB byte first over a
// valid/ready byte link.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   trace_valid              sample the lane fields this cycle
//   instr_a/b, haz_a/b,
//   alu_a/b                  4-bit codes for lanes A and B
//   out_data, out_valid,
//   out_ready                byte stream, transfer on out_valid && out_ready
//   bad_code                 sticky: an illegal code was sanitised
//   ovf                      sticky: at least one sample was dropped
// Configuration macro: TRACE_DEDUP_EN -- when defined, a sample is captured
// only if its sanitised fields differ from the last captured sample.
module dbg_trace_encoder #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       trace_valid,
    input  logic [3:0] instr_a,
    input  logic [3:0] instr_b,
    input  logic [3:0] haz_a,
    input  logic [3:0] haz_b,
    input  logic [3:0] alu_a,
    input  logic [3:0] alu_b,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       bad_code,
    output logic       ovf
);

    import trace_pkg::*;

    // ---------------- sanitise ----------------
    instruction_t   s_instr_a, s_instr_b;
    hazard_signal_t s_haz_a, s_haz_b;
    alu_op_t        s_alu_a, s_alu_b;
    logic           any_bad;
    logic [23:0]    cur_fields;

    always_comb begin
        s_instr_a  = (instr_a > INSTR_MAX) ? INSTR_NONE : instr_a;
        s_instr_b  = (instr_b > INSTR_MAX) ? INSTR_NONE : instr_b;
        s_haz_a    = (haz_a > HAZ_MAX) ? HAZ_NONE : haz_a;
        s_haz_b    = (haz_b > HAZ_MAX) ? HAZ_NONE : haz_b;
        s_alu_a    = (alu_a > ALU_MAX) ? ALU_NONE : alu_a;
        s_alu_b    = (alu_b > ALU_MAX) ? ALU_NONE : alu_b;
        any_bad    = (instr_a > INSTR_MAX) || (instr_b > INSTR_MAX) ||
                     (haz_a > HAZ_MAX) || (haz_b > HAZ_MAX) ||
                     (alu_a > ALU_MAX) || (alu_b > ALU_MAX);
        cur_fields = {s_instr_a, s_instr_b, s_haz_a, s_haz_b, s_alu_a, s_alu_b};
    end

    // ---------------- capture / overflow ----------------
    logic       fifo_full, fifo_empty, fifo_pop;
    logic [31:0] fifo_head;
    logic       want_sample;
    logic       mark_now, drop_now, push_en;
    logic [3:0] drop_cnt;
    logic       ovf_pending;
    logic [3:0] delta_cnt;
    logic [3:0] marker_cnt;
    trace_rec_t push_rec;

`ifdef TRACE_DEDUP_EN
    logic [23:0] last_fields;
    logic        last_ok;

    assign want_sample = trace_valid && (!last_ok || (cur_fields != last_fields));

    // Reference for duplicate suppression; a marker forces the next sample through.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_fields <= '0;
            last_ok     <= 1'b0;
        end else if (mark_now) begin
            last_ok     <= 1'b0;
        end else if (want_sample && !fifo_full) begin
            last_fields <= cur_fields;
            last_ok     <= 1'b1;
        end
    end
`else
    assign want_sample = trace_valid;
`endif

    always_comb begin
        // A pending marker takes the slot; a sample offered in that same cycle is
        // folded into the marker's drop count.
        mark_now   = ovf_pending && !fifo_full;
        drop_now   = want_sample && fifo_full;
        push_en    = mark_now || (want_sample && !fifo_full);
        marker_cnt = want_sample ? sat_inc(drop_cnt) : drop_cnt;
        if (mark_now) begin
            push_rec = trace_rec_t'({HDR_OVF, 24'h0, marker_cnt});
        end else begin
            push_rec = trace_rec_t'({HDR_SAMPLE, cur_fields, delta_cnt});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt    <= '0;
            ovf_pending <= 1'b0;
            ovf         <= 1'b0;
            bad_code    <= 1'b0;
            delta_cnt   <= '0;
        end else begin
            if (trace_valid && any_bad) begin
                bad_code <= 1'b1;
            end
            if (mark_now) begin
                drop_cnt    <= '0;
                ovf_pending <= 1'b0;
            end else if (drop_now) begin
                drop_cnt    <= sat_inc(drop_cnt);
                ovf_pending <= 1'b1;
                ovf         <= 1'b1;
            end
            // delta_cnt stays 0 until the first record after reset, then counts
            // cycles since the last pushed record.
            if (push_en) begin
                delta_cnt <= 4'd1;
            end else if (delta_cnt != '0) begin
                delta_cnt <= sat_inc(delta_cnt);
            end
        end
    end

    trace_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_en),
        .push_data (push_rec),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ---------------- serializer ----------------
    ser_state_t  state;
    logic [1:0]  beat;
    logic [31:0] shreg;

    // Pop when idle, or on the last beat's handshake so the next record follows
    // without a bubble.
    assign fifo_pop  = !fifo_empty &&
                       ((state == ST_IDLE) || ((beat == 2'd3) && out_ready));
    assign out_valid = (state == ST_SEND);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            beat  <= '0;
            shreg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        shreg <= fifo_head;
                        beat  <= '0;
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (out_ready) begin
                        if (beat == 2'd3) begin
                            beat <= '0;
                            if (!fifo_empty) begin
                                shreg <= fifo_head;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            beat <= beat + 2'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        out_data = '0;
        case (beat)
            2'd0:    out_data = shreg[31:24];
            2'd1:    out_data = shreg[23:16];
            2'd2:    out_data = shreg[15:8];
            default: out_data = shreg[7:0];
        endcase
    end

endmodule

// File: tb/tb_dbg_trace_encoder.sv
module tb_dbg_trace_encoder;

    localparam int unsigned DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       trace_valid;
    logic [3:0] instr_a, instr_b, haz_a, haz_b, alu_a, alu_b;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       bad_code;
    logic       ovf;

    always #5 clk = ~clk;

    dbg_trace_encoder #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .trace_valid (trace_valid),
        .instr_a     (instr_a),
        .instr_b     (instr_b),
        .haz_a       (haz_a),
        .haz_b       (haz_b),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .bad_code    (bad_code),
        .ovf         (ovf)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_cap = -1;
    int          bytes_seen = 0;
    logic [7:0]  exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted byte is compared with the next expected byte.
    always @(negedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL byte_unexpected: observed %02h expected none", out_data);
            end
            if (exp_q.size() != 0) begin
                check("byte", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
            end
            bytes_seen++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] san_ih(input logic [3:0] c);
        return (c > 4'hB) ? 4'hB : c;
    endfunction

    function automatic logic [3:0] san_alu(input logic [3:0] c);
        return (c > 4'hB) ? 4'hA : c;
    endfunction

    task automatic drive(input logic [3:0] ia, ib, ha, hb, aa, ab);
        trace_valid = 1'b1;
        instr_a = ia; instr_b = ib; haz_a = ha; haz_b = hb; alu_a = aa; alu_b = ab;
    endtask

    // Offer a sample that must be captured at the next edge and predict its bytes.
    task automatic capture(input logic [3:0] ia, ib, ha, hb, aa, ab);
        logic [31:0] rec;
        logic [3:0]  d;
        int          gap;
        drive(ia, ib, ha, hb, aa, ab);
        tick();
        if (last_cap < 0) begin
            d = 4'h0;
        end else begin
            gap = cyc - last_cap;
            d = (gap > 15) ? 4'hF : 4'(gap);
        end
        last_cap = cyc;
        rec = {4'h5, san_ih(ia), san_ih(ib), san_ih(ha), san_ih(hb), san_alu(aa), san_alu(ab), d};
        exp_q.push_back(rec[31:24]);
        exp_q.push_back(rec[23:16]);
        exp_q.push_back(rec[15:8]);
        exp_q.push_back(rec[7:0]);
        trace_valid = 1'b0;
    endtask

    // Offer a sample that produces no record (dropped or suppressed).
    task automatic offer_only(input logic [3:0] ia, ib, ha, hb, aa, ab);
        drive(ia, ib, ha, hb, aa, ab);
        tick();
        trace_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_bytes(input string tag, input int target, input int budget);
        int n = 0;
        while (bytes_seen < target && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(bytes_seen), 32'(target));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        trace_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        last_cap = -1;
        exp_q.delete();
    endtask

    initial begin
        int b0;
        logic [7:0] held;
        trace_valid = 1'b0;
        out_ready = 1'b0;
        instr_a = '0; instr_b = '0; haz_a = '0; haz_b = '0; alu_a = '0; alu_b = '0;
        do_reset();

        check("rst_out_valid", {31'h0, out_valid}, 32'd0);
        check("rst_out_data", {24'h0, out_data}, 32'd0);
        check("rst_bad_code", {31'h0, bad_code}, 32'd0);
        check("rst_ovf", {31'h0, ovf}, 32'd0);

        // Single sample: 50 2B B0 10, beat 0 valid one edge after capture.
        out_ready = 1'b1;
        capture(4'h0, 4'h2, 4'hB, 4'hB, 4'h0, 4'h1);
        check("t1_no_valid_yet", {31'h0, out_valid}, 32'd0);
        tick();
        check("t1_valid_latency", {31'h0, out_valid}, 32'd1);
        check("t1_first_byte", {24'h0, out_data}, 32'h50);
        wait_drain("t1_drain", 20);
        check("t1_bad_code", {31'h0, bad_code}, 32'd0);

        // Stall during beat 1.
        b0 = bytes_seen;
        capture(4'h1, 4'h3, 4'h0, 4'h2, 4'h5, 4'h7);
        wait_bytes("t2_beat0", b0 + 1, 10);
        out_ready = 1'b0;
        held = out_data;
        check("t2_beat1_byte", {24'h0, held}, 32'h30);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_stall_valid", {31'h0, out_valid}, 32'd1);
            check("t2_stall_data", {24'h0, out_data}, {24'h0, held});
        end
        out_ready = 1'b1;
        wait_drain("t2_drain", 20);

        // Illegal codes are sanitised and flagged.
        capture(4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 4'hC);
        check("t4_bad_set", {31'h0, bad_code}, 32'd1);
        wait_drain("t4_drain", 20);
        tick();
        tick();
        check("t4_bad_sticky", {31'h0, bad_code}, 32'd1);

        // Back-to-back records stream without a bubble.
        capture(4'h2, 4'h4, 4'h1, 4'h0, 4'h3, 4'h9);
        capture(4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA);
        for (int i = 0; i < 8; i++) begin
            check("t5_no_bubble", {31'h0, out_valid}, 32'd1);
            tick();
        end
        wait_drain("t5_drain", 20);

        // Overflow: serializer holds one record, FIFO fills with 8, 3 dropped.
        do_reset();
        check("t3_ovf_clear", {31'h0, ovf}, 32'd0);
        out_ready = 1'b0;
        capture(4'h9, 4'h8, 4'h7, 4'h6, 4'h5, 4'h4);
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            capture(4'(i), 4'(i + 1), 4'(11 - i), 4'(i), 4'(i + 2), 4'(9 - i));
        end
        check("t3_ovf_before_drop", {31'h0, ovf}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            offer_only(4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1);
        end
        check("t3_ovf_set", {31'h0, ovf}, 32'd1);
        exp_q.push_back(8'hE0);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h03);
        out_ready = 1'b1;
        wait_drain("t3_drain", 200);
        check("t3_ovf_sticky", {31'h0, ovf}, 32'd1);

        // Identical sample for 4 cycles then a change.
        do_reset();
        check("t6_ovf_reset", {31'h0, ovf}, 32'd0);
        check("t6_bad_reset", {31'h0, bad_code}, 32'd0);
        out_ready = 1'b1;
        capture(4'h3, 4'h3, 4'h1, 4'h1, 4'h2, 4'h2);
`ifdef TRACE_DEDUP_EN
        for (int i = 0; i < 3; i++) begin
            offer_only(4'h3, 4'h3, 4'h1, 4'h1, 4'h2, 4'h2);
        end
`else
        for (int i = 0; i < 3; i++) begin
            capture(4'h3, 4'h3, 4'h1, 4'h1, 4'h2, 4'h2);
        end
`endif
        capture(4'h4, 4'h3, 4'h1, 4'h1, 4'h2, 4'h2);
        wait_drain("t6_drain", 60);

        // Reset during beat 2 abandons the record.
        b0 = bytes_seen;
        capture(4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1);
        wait_bytes("t6_two_beats", b0 + 2, 10);
        out_ready = 1'b0;
        check("t6_beat2_valid", {31'h0, out_valid}, 32'd1);
        check("t6_beat2_byte", {24'h0, out_data}, 32'h32);
        reset = 1'b1;
        tick();
        check("t6_rst_valid", {31'h0, out_valid}, 32'd0);
        check("t6_rst_data", {24'h0, out_data}, 32'd0);
        reset = 1'b0;
        exp_q.delete();
        last_cap = -1;
        out_ready = 1'b1;
        tick();
        tick();
        check("t6_no_resume", {31'h0, out_valid}, 32'd0);
        capture(4'hA, 4'hB, 4'h0, 4'h1, 4'h2, 4'h3);
        wait_drain("t6_after_reset", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
